// File: rtl/acs_unit_if.sv
// Port bundle for the serial ACS engine: symbol input, PM bank access,
// survivor output. The engine uses the master side.
interface acs_unit_if #(
    parameter int M  = 4,
    parameter int Wm = 8
);
    localparam int S = 1 << M;

    logic           frame_start;
    logic           sym_valid;
    logic [1:0]     sym;
    logic           sym_ready;
    logic [M-1:0]   rd_idx0;
    logic [M-1:0]   rd_idx1;
    logic [Wm-1:0]  rd_pm0;
    logic [Wm-1:0]  rd_pm1;
    logic           wr_en;
    logic [M-1:0]   wr_idx;
    logic [Wm-1:0]  wr_pm;
    logic           init_frame;
    logic           swap_banks;
    logic           surv_valid;
    logic           surv_ready;
    logic [S-1:0]   surv_bits;
    logic [M-1:0]   best_state;
    logic [Wm-1:0]  best_pm;

    modport master (
        input  frame_start, sym_valid, sym, rd_pm0, rd_pm1, surv_ready,
        output sym_ready, rd_idx0, rd_idx1, wr_en, wr_idx, wr_pm,
               init_frame, swap_banks, surv_valid, surv_bits, best_state, best_pm
    );

    modport slave (
        output frame_start, sym_valid, sym, rd_pm0, rd_pm1, surv_ready,
        input  sym_ready, rd_idx0, rd_idx1, wr_en, wr_idx, wr_pm,
               init_frame, swap_banks, surv_valid, surv_bits, best_state, best_pm
    );
endinterface

// File: rtl/acs_unit.sv
// State-serial add-compare-select for a K=5 rate-1/2 hard-decision Viterbi decoder.
// One trellis state per cycle; path metrics live in an external ping-pong bank.
module acs_unit #(
    parameter int             K  = 5,
    parameter int             Wm = 8,
    parameter logic [K-1:0]   G0 = 5'b10011,
    parameter logic [K-1:0]   G1 = 5'b11101
) (
    input  logic        clk,
    input  logic        rst,
    acs_unit_if.master  bus
);
    localparam int M = K - 1;
    localparam int S = 1 << M;
    localparam logic [Wm-1:0] PM_INF   = '1;
    localparam logic [Wm-1:0] PM_SAT   = {{(Wm-1){1'b1}}, 1'b0};
    localparam logic [M-1:0]  CNT_LAST = '1;

    typedef enum logic [1:0] {IDLE, WAIT_SYM, RUN, OUT} state_t;

    state_t         state_reg, state_next;
    logic [M-1:0]   cnt_reg;
    logic [Wm-1:0]  norm_reg;
    logic [1:0]     sym_reg;
    logic [Wm-1:0]  run_min_reg;
    logic [M-1:0]   run_best_reg;
    logic [S-1:0]   surv_acc_reg;
    logic [S-1:0]   surv_bits_reg;
    logic [M-1:0]   best_state_reg;
    logic [Wm-1:0]  best_pm_reg;

    logic           init_c, swap_c, ready_c, wr_en_c, valid_c;
    logic           last;

    logic [1:0][M-1:0]  pred;
    logic [1:0][1:0]    bm;
    logic [1:0][Wm-1:0] rd_pm;
    logic [1:0][Wm-1:0] acc;

    logic           take1;
    logic [Wm-1:0]  sel_pm;
    logic [Wm-1:0]  min_next;
    logic [M-1:0]   best_next;
    logic [S-1:0]   surv_now;

    assign rd_pm[0] = bus.rd_pm0;
    assign rd_pm[1] = bus.rd_pm1;
    assign last     = (cnt_reg == CNT_LAST);

    // Branch lane gi handles predecessor p_gi = {gi, cnt[M-1:1]} with input bit cnt[0].
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_branch
            localparam logic HI = (gi == 1);
            logic [K-1:0]  enc;
            logic          c0, c1;
            logic [Wm-1:0] rel;
            logic [Wm:0]   sum;

            assign pred[gi] = {HI, cnt_reg[M-1:1]};
            assign enc      = {pred[gi], cnt_reg[0]};
            assign c0       = ^(enc & G0);
            assign c1       = ^(enc & G1);
            assign bm[gi]   = {1'b0, sym_reg[1] ^ c0} + {1'b0, sym_reg[0] ^ c1};
            assign rel      = rd_pm[gi] - norm_reg;
            assign sum      = {1'b0, rel} + {{(Wm-1){1'b0}}, bm[gi]};
            // INF is sticky; finite sums clamp one below INF so they never alias it.
            assign acc[gi]  = (rd_pm[gi] == PM_INF)      ? PM_INF :
                              (sum > {1'b0, PM_SAT})     ? PM_SAT : sum[Wm-1:0];
        end
    endgenerate

    // Strict compare: on a tie the p0 branch survives.
    assign take1  = (acc[1] < acc[0]);
    assign sel_pm = take1 ? acc[1] : acc[0];

    always_comb begin
        min_next  = run_min_reg;
        best_next = run_best_reg;
        if ((cnt_reg == '0) || (sel_pm < run_min_reg)) begin
            min_next  = sel_pm;
            best_next = cnt_reg;
        end
    end

    always_comb begin
        surv_now          = surv_acc_reg;
        surv_now[cnt_reg] = take1;
    end

    always_comb begin
        state_next = state_reg;
        init_c     = 1'b0;
        swap_c     = 1'b0;
        ready_c    = 1'b0;
        wr_en_c    = 1'b0;
        valid_c    = 1'b0;
        if (!rst) begin
            case (state_reg)
                IDLE: begin
                    if (bus.frame_start) begin
                        init_c     = 1'b1;
                        swap_c     = 1'b1;
                        state_next = WAIT_SYM;
                    end
                end
                WAIT_SYM: begin
                    ready_c = 1'b1;
                    if (bus.frame_start) begin
                        init_c = 1'b1;
                        swap_c = 1'b1;
                    end else if (bus.sym_valid) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    wr_en_c = 1'b1;
                    if (last) begin
                        swap_c     = 1'b1;
                        state_next = OUT;
                    end
                end
                OUT: begin
                    valid_c = 1'b1;
                    if (bus.surv_ready) begin
                        state_next = WAIT_SYM;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            norm_reg       <= '0;
            sym_reg        <= '0;
            run_min_reg    <= '0;
            run_best_reg   <= '0;
            surv_acc_reg   <= '0;
            surv_bits_reg  <= '0;
            best_state_reg <= '0;
            best_pm_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (init_c) begin
                norm_reg <= '0;
            end
            if ((state_reg == WAIT_SYM) && (state_next == RUN)) begin
                sym_reg      <= bus.sym;
                cnt_reg      <= '0;
                surv_acc_reg <= '0;
            end
            if (state_reg == RUN) begin
                cnt_reg      <= cnt_reg + M'(1);
                run_min_reg  <= min_next;
                run_best_reg <= best_next;
                surv_acc_reg <= surv_now;
                // Next step's metrics are read relative to this step's minimum.
                if (last) begin
                    norm_reg       <= min_next;
                    surv_bits_reg  <= surv_now;
                    best_state_reg <= best_next;
                    best_pm_reg    <= min_next;
                end
            end
        end
    end

    assign bus.sym_ready  = ready_c;
    assign bus.init_frame = init_c;
    assign bus.swap_banks = swap_c;
    assign bus.wr_en      = wr_en_c;
    assign bus.surv_valid = valid_c;
    assign bus.rd_idx0    = wr_en_c ? pred[0] : '0;
    assign bus.rd_idx1    = wr_en_c ? pred[1] : '0;
    assign bus.wr_idx     = wr_en_c ? cnt_reg : '0;
    assign bus.wr_pm      = wr_en_c ? sel_pm  : '0;
    assign bus.surv_bits  = surv_bits_reg;
    assign bus.best_state = best_state_reg;
    assign bus.best_pm    = best_pm_reg;
endmodule

// File: tb/tb_acs_unit.sv
// Directed bench for acs_unit: a ping-pong PM bank model plus hand-computed
// expected metrics, survivors and best states.
module tb_acs_unit;
    localparam int S = 16;

    logic clk;
    logic rst;

    acs_unit_if bus ();

    acs_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PM bank: reads from bank[bank_sel], writes into the other half, swap flips.
    logic [7:0] bank [2][S];
    logic       bank_sel = 1'b0;
    logic       poke_en;
    logic [3:0] poke_idx;
    logic [7:0] poke_val;

    assign bus.rd_pm0 = bank[bank_sel][bus.rd_idx0];
    assign bus.rd_pm1 = bank[bank_sel][bus.rd_idx1];

    always @(posedge clk) begin
        if (bus.init_frame) begin
            for (int i = 0; i < S; i++) begin
                bank[~bank_sel][i] <= (i == 0) ? 8'h00 : 8'hFF;
            end
        end
        if (bus.wr_en) begin
            bank[~bank_sel][bus.wr_idx] <= bus.wr_pm;
        end
        if (bus.swap_banks) begin
            bank_sel <= ~bank_sel;
        end
        if (poke_en) begin
            bank[bank_sel][poke_idx] <= poke_val;
        end
    end

    int   swap_cnt, init_cnt, wr_cnt, sat_hits, odd_swap;
    logic mon_clr;

    always @(posedge clk) begin
        if (mon_clr) begin
            swap_cnt <= 0;
            init_cnt <= 0;
            wr_cnt   <= 0;
            sat_hits <= 0;
        end else begin
            if (bus.swap_banks) swap_cnt <= swap_cnt + 1;
            if (bus.init_frame) init_cnt <= init_cnt + 1;
            if (bus.wr_en) wr_cnt <= wr_cnt + 1;
            if (bus.wr_en && bus.wr_pm == 8'hFE) sat_hits <= sat_hits + 1;
        end
        if (bus.swap_banks && !bus.init_frame && !(bus.wr_en && bus.wr_idx == 4'hF)) begin
            odd_swap <= odd_swap + 1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [15:0] got_surv;
    logic [3:0]  got_bs;
    logic [7:0]  got_bpm;

    task automatic do_frame_start();
        @(negedge clk);
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
    endtask

    task automatic poke(input logic [3:0] idx, input logic [7:0] val);
        poke_idx = idx;
        poke_val = val;
        poke_en  = 1'b1;
        @(negedge clk);
        poke_en  = 1'b0;
    endtask

    task automatic send_sym(input logic [1:0] s, input int stall);
        int k;
        k = 0;
        while (!bus.sym_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_eq("sym_ready_wait", 32'(bus.sym_ready), 1);
        bus.sym       = s;
        bus.sym_valid = 1'b1;
        @(negedge clk);
        bus.sym_valid = 1'b0;
        k = 0;
        while (!bus.surv_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_eq("step_latency", 32'(k), S);
        got_surv = bus.surv_bits;
        got_bs   = bus.best_state;
        got_bpm  = bus.best_pm;
        for (int c = 0; c < stall; c++) begin
            @(negedge clk);
            check_eq("stall_valid", 32'(bus.surv_valid), 1);
            check_eq("stall_sym_ready", 32'(bus.sym_ready), 0);
            check_eq("stall_wr_en", 32'(bus.wr_en), 0);
            check_eq("stall_surv_bits", 32'(bus.surv_bits), 32'(got_surv));
            check_eq("stall_best_state", 32'(bus.best_state), 32'(got_bs));
            check_eq("stall_best_pm", 32'(bus.best_pm), 32'(got_bpm));
        end
        bus.surv_ready = 1'b1;
        @(negedge clk);
        bus.surv_ready = 1'b0;
        $display("step sym=%b surv=%h best_state=%0d best_pm=%0d", s, got_surv, got_bs, got_bpm);
    endtask

    logic [7:0] exp_step3 [S] = '{8'd1, 8'd3, 8'd4, 8'd4, 8'd1, 8'd1, 8'd2, 8'd0,
                                  8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] exp_tie [S]   = '{8'd10, 8'd10, 8'd11, 8'd11, 8'd11, 8'd11, 8'd10, 8'd10,
                                  8'd11, 8'd11, 8'd10, 8'd10, 8'd10, 8'd10, 8'd11, 8'd11};

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int k;
        odd_swap       = 0;
        rst            = 1'b1;
        bus.frame_start = 1'b0;
        bus.sym_valid  = 1'b0;
        bus.sym        = 2'b00;
        bus.surv_ready = 1'b0;
        poke_en        = 1'b0;
        poke_idx       = '0;
        poke_val       = '0;
        mon_clr        = 1'b1;
        repeat (3) @(negedge clk);
        mon_clr = 1'b0;

        // Reset values
        check_eq("rst_sym_ready", 32'(bus.sym_ready), 0);
        check_eq("rst_wr_en", 32'(bus.wr_en), 0);
        check_eq("rst_surv_valid", 32'(bus.surv_valid), 0);
        check_eq("rst_init_frame", 32'(bus.init_frame), 0);
        check_eq("rst_swap", 32'(bus.swap_banks), 0);
        check_eq("rst_rd_idx1", 32'(bus.rd_idx1), 0);
        check_eq("rst_surv_bits", 32'(bus.surv_bits), 0);
        check_eq("rst_best_pm", 32'(bus.best_pm), 0);
        rst = 1'b0;

        // Reset in the middle of RUN
        do_frame_start();
        bus.sym       = 2'b00;
        bus.sym_valid = 1'b1;
        @(negedge clk);
        bus.sym_valid = 1'b0;
        k = 0;
        while (!(bus.wr_en && bus.wr_idx == 4'd5) && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_eq("midrun_reach_cnt5", 32'(bus.wr_idx), 5);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrun_wr_en", 32'(bus.wr_en), 0);
        check_eq("midrun_sym_ready", 32'(bus.sym_ready), 0);
        check_eq("midrun_surv_valid", 32'(bus.surv_valid), 0);
        check_eq("midrun_swap", 32'(bus.swap_banks), 0);
        rst = 1'b0;
        @(negedge clk);

        // First step from a fresh frame, then two 00 steps exercising normalization
        do_frame_start();
        clear_mon();
        send_sym(2'b11, 0);
        check_eq("s1_surv_bits", 32'(got_surv), 32'h0000);
        check_eq("s1_best_state", 32'(got_bs), 1);
        check_eq("s1_best_pm", 32'(got_bpm), 0);
        check_eq("s1_swap_count", 32'(swap_cnt), 1);
        check_eq("s1_init_count", 32'(init_cnt), 0);
        check_eq("s1_write_count", 32'(wr_cnt), 16);
        check_eq("s1_pm0", 32'(bank[bank_sel][0]), 2);
        check_eq("s1_pm1", 32'(bank[bank_sel][1]), 0);
        check_eq("s1_pm2", 32'(bank[bank_sel][2]), 32'hFF);
        check_eq("s1_pm15", 32'(bank[bank_sel][15]), 32'hFF);

        send_sym(2'b00, 0);
        check_eq("s2_surv_bits", 32'(got_surv), 32'h0000);
        check_eq("s2_best_state", 32'(got_bs), 2);
        check_eq("s2_best_pm", 32'(got_bpm), 1);
        check_eq("s2_pm1", 32'(bank[bank_sel][1]), 4);
        check_eq("s2_pm3", 32'(bank[bank_sel][3]), 1);
        check_eq("s2_pm4", 32'(bank[bank_sel][4]), 32'hFF);

        // Third step also holds OUT for 10 cycles with surv_ready low
        send_sym(2'b00, 10);
        check_eq("s3_best_state", 32'(got_bs), 7);
        check_eq("s3_best_pm", 32'(got_bpm), 0);
        check_eq("s3_surv_bits", 32'(got_surv), 32'h0000);
        for (int i = 0; i < S; i++) begin
            check_eq($sformatf("s3_pm%0d", i), 32'(bank[bank_sel][i]), 32'(exp_step3[i]));
        end

        // Equal metrics on both branches: ties keep p0
        do_frame_start();
        for (int i = 0; i < S; i++) poke(4'(i), 8'd10);
        send_sym(2'b00, 0);
        check_eq("tie_surv_bits", 32'(got_surv), 32'h2442);
        check_eq("tie_best_state", 32'(got_bs), 0);
        check_eq("tie_best_pm", 32'(got_bpm), 10);
        for (int i = 0; i < S; i++) begin
            check_eq($sformatf("tie_pm%0d", i), 32'(bank[bank_sel][i]), 32'(exp_tie[i]));
        end

        // Saturation just below INF, then recovery through normalization
        do_frame_start();
        poke(4'd0, 8'd254);
        poke(4'd8, 8'd253);
        send_sym(2'b11, 0);
        check_eq("sat_surv_bits", 32'(got_surv), 32'h0001);
        check_eq("sat_best_state", 32'(got_bs), 0);
        check_eq("sat_best_pm", 32'(got_bpm), 253);
        check_eq("sat_pm0", 32'(bank[bank_sel][0]), 253);
        check_eq("sat_pm1", 32'(bank[bank_sel][1]), 254);
        check_eq("sat_pm2", 32'(bank[bank_sel][2]), 32'hFF);
        send_sym(2'b11, 0);
        check_eq("satn_best_state", 32'(got_bs), 1);
        check_eq("satn_best_pm", 32'(got_bpm), 0);
        check_eq("satn_pm0", 32'(bank[bank_sel][0]), 2);
        check_eq("satn_pm3", 32'(bank[bank_sel][3]), 2);

        // Repeated frame_start in WAIT_SYM, then 20 all-zero symbols
        clear_mon();
        do_frame_start();
        do_frame_start();
        check_eq("refs_init_count", 32'(init_cnt), 2);
        check_eq("refs_swap_count", 32'(swap_cnt), 2);
        for (int n = 0; n < 20; n++) begin
            send_sym(2'b00, 0);
            check_eq($sformatf("zero%0d_best_state", n), 32'(got_bs), 0);
            check_eq($sformatf("zero%0d_best_pm", n), 32'(got_bpm), 0);
            check_eq($sformatf("zero%0d_surv0", n), 32'(got_surv[0]), 0);
        end
        check_eq("zero_no_saturation", 32'(sat_hits), 0);
        check_eq("zero_write_count", 32'(wr_cnt), 320);
        check_eq("swap_only_with_last_write", 32'(odd_swap), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
